mb_bus_cycle_sequencer: RTL and testbench
=========================================

// Module: mb_bus_cycle_sequencer
// PURPOSE
//  Motherboard-side bus cycle sequencer; sits directly upstream of the 6800 emulation stage.
//  Converts an accelerator CPU cycle into a 68000-timed motherboard cycle on the 7.09 MHz bus.
//  Synchronises the CPU strobe, drives MB_AS/MB_UDS/MB_LDS and samples MB_DTACK and MC6800_DTACK.
//  Returns CPU_DTACK, or CPU_BERR on timeout.
// PARAMETERS
//  SYNC_STAGES     2    flops on CPU_AS/CPU_UDS/CPU_LDS into the MB_CLK domain (2..3)
//  TIMEOUT_CYCLES  256  MB_CLK cycles in WAIT before bus error (only with BERR timeout compiled in)
//  WR_DS_DELAY     1    MB_CLK cycles between MB_AS and MB_UDS/LDS assertion on writes (0..2)
// PORTS
//  MB_CLK        in   1  motherboard 7.09 MHz clock; sole clock, all logic on posedge
//  RESET         in   1  synchronous, active-high reset
//  CPU_AS        in   1  accelerator address strobe, active low, asynchronous to MB_CLK
//  CPU_UDS       in   1  upper data strobe, active low, async
//  CPU_LDS       in   1  lower data strobe, active low, async
//  CPU_RW        in   1  1=read 0=write; stable while CPU_AS low
//  MB_SEL        in   1  address decode: 1 = cycle targets motherboard space
//  MB_DTACK      in   1  motherboard DTACK, active low, MB_CLK domain
//  MC6800_DTACK  in   1  DTACK from the 6800 emulation stage, active low
//  MB_AS         out  1  motherboard address strobe, active low, registered
//  MB_UDS        out  1  motherboard upper data strobe, active low, registered
//  MB_LDS        out  1  motherboard lower data strobe, active low, registered
//  CPU_DTACK     out  1  cycle-complete to accelerator, active low, registered
//  CPU_BERR      out  1  bus error to accelerator, active low, registered
//  CYCLE_ACTIVE  out  1  1 while state != IDLE (for buffer/latch enables)
// BEHAVIOUR
//  - Reset: state=IDLE, sync chains=1. MB_AS/MB_UDS/MB_LDS/CPU_DTACK/CPU_BERR=1, CYCLE_ACTIVE=0.
//    Reset in any state returns to IDLE on the same edge; no partial strobe is held.
//  - as_s/uds_s/lds_s are the SYNC_STAGES-delayed CPU strobes; FSM uses only synced copies.
//  - IDLE: if as_s==0 && MB_SEL==1 -> ASSERT; MB_AS=0 registered on this edge.
//    Latency: CPU_AS low -> MB_AS low = SYNC_STAGES+1 edges.
//  - ASSERT: read -> UDS/LDS = uds_s/lds_s on entry, -> WAIT.
//    Write -> hold WR_DS_DELAY cycles (counter), then drive UDS/LDS, -> WAIT.
//  - WAIT: MB_DTACK==0 || MC6800_DTACK==0 sampled -> DONE with CPU_DTACK=0.
//    Simultaneous both low = single completion.
//  - DONE: MB strobes and CPU_DTACK held low until as_s==1.
//    Then -> IDLE; all strobes and DTACK go 1 on the same edge.
//  - Abort: as_s==1 in ASSERT or WAIT -> IDLE immediately; strobes negated, no DTACK issued.
//  - MB_SEL is sampled only in IDLE; changes mid-cycle are ignored.
//  - Back-to-back: IDLE needs as_s==1 seen once.
//    A new cycle never starts in the edge that ends the previous one (min 1 idle cycle, MB_AS high).
//  - CPU_DTACK and CPU_BERR are never low together.
// CONFIGURATION
//  MB_BERR_TIMEOUT_EN defined:
//    - 9-bit wait counter cleared on WAIT entry, increments each WAIT cycle.
//    - At count==TIMEOUT_CYCLES-1 without DTACK -> BERR: strobes negated, CPU_BERR=0.
//    - BERR held until as_s==1, then -> IDLE.
//    - DTACK arriving on the terminal-count edge wins; the cycle goes to DONE.
//  Not defined: no counter and no BERR state; WAIT persists until DTACK or abort; CPU_BERR tied 1.
// STRUCTURE
//  Shared package mb_bus_pkg:
//    - state enum IDLE/ASSERT/WAIT/DONE/BERR
//    - MB_TIMEOUT_W=9
//    - strobe-inactive constant 1'b1
//  Sub-module mb_sync_chain: SYNC_STAGES-deep resettable (to 1) synchroniser, instantiated per CPU strobe.
//  FSM, delay counter and timeout counter stay in the top module.
// TESTING
//  1. Read, MB_DTACK low 4 cycles after MB_AS:
//     - MB_AS low 3 edges after CPU_AS (SYNC_STAGES=2); UDS/LDS low with AS.
//     - CPU_DTACK low 1 edge after DTACK; all high 1 edge after as_s high.
//  2. Write, WR_DS_DELAY=1: UDS/LDS low exactly 1 edge after MB_AS; data-phase order checked by assertion.
//  3. 6800 cycle: MB_DTACK held high, MC6800_DTACK low after 10 edges -> CPU_DTACK low next edge.
//  4. CPU_AS negated while in WAIT -> IDLE next edge; MB_AS=1 and CPU_DTACK never asserted.
//  5. With MB_BERR_TIMEOUT_EN, TIMEOUT_CYCLES=16, no DTACK:
//     - CPU_BERR low exactly 16 edges after WAIT entry; MB_AS high the same edge.
//  6. RESET pulsed in DONE -> next edge all outputs 1, CYCLE_ACTIVE 0.
//     MB_SEL=0 cycle -> no motherboard strobes.

Source files
------------

// File: rtl/mb_bus_pkg.sv
// Shared types and constants for the motherboard bus cycle sequencer.
package mb_bus_pkg;
  typedef enum logic [2:0] {IDLE, ASSERT, WAIT, DONE, BERR} mb_state_t;
  localparam int unsigned MB_TIMEOUT_W = 9;
  localparam logic STROBE_OFF = 1'b1;
endpackage

// File: rtl/mb_sync_chain.sv
// Resettable multi-flop synchroniser for an active-low CPU strobe; resets to the inactive level.
module mb_sync_chain
  import mb_bus_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) stage <= {STAGES{STROBE_OFF}};
    else     stage <= {stage[STAGES-2:0], d};
  end

  assign q = stage[STAGES-1];
endmodule

// File: rtl/mb_bus_cycle_sequencer.sv
// Converts an accelerator CPU cycle into a 68000-timed motherboard bus cycle.
// Optional bus-error timeout in WAIT is compiled in with MB_BERR_TIMEOUT_EN.
module mb_bus_cycle_sequencer
  import mb_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned WR_DS_DELAY    = 1
) (
  input  logic MB_CLK,
  input  logic RESET,
  input  logic CPU_AS,
  input  logic CPU_UDS,
  input  logic CPU_LDS,
  input  logic CPU_RW,
  input  logic MB_SEL,
  input  logic MB_DTACK,
  input  logic MC6800_DTACK,
  output logic MB_AS,
  output logic MB_UDS,
  output logic MB_LDS,
  output logic CPU_DTACK,
  output logic CPU_BERR,
  output logic CYCLE_ACTIVE
);
  localparam int unsigned DLY_LAST  = (WR_DS_DELAY > 0) ? WR_DS_DELAY - 1 : 0;
  localparam bit          WR_DS_NOW = (WR_DS_DELAY == 0);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || WR_DS_DELAY > 2 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << MB_TIMEOUT_W)) begin : g_bad_params
    $error("mb_bus_cycle_sequencer: parameter out of range");
  end

  mb_state_t  state;
  logic       as_s, uds_s, lds_s;
  logic [1:0] dly_cnt;
  logic       ds_pending;
`ifdef MB_BERR_TIMEOUT_EN
  logic [MB_TIMEOUT_W-1:0] wait_cnt;
`endif

  mb_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_as  (.clk(MB_CLK), .rst(RESET), .d(CPU_AS),  .q(as_s));
  mb_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_uds (.clk(MB_CLK), .rst(RESET), .d(CPU_UDS), .q(uds_s));
  mb_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_lds (.clk(MB_CLK), .rst(RESET), .d(CPU_LDS), .q(lds_s));

  always_ff @(posedge MB_CLK) begin
    if (RESET) begin
      state        <= IDLE;
      MB_AS        <= STROBE_OFF;
      MB_UDS       <= STROBE_OFF;
      MB_LDS       <= STROBE_OFF;
      CPU_DTACK    <= STROBE_OFF;
      CYCLE_ACTIVE <= 1'b0;
      dly_cnt      <= '0;
      ds_pending   <= 1'b0;
`ifdef MB_BERR_TIMEOUT_EN
      CPU_BERR     <= STROBE_OFF;
      wait_cnt     <= '0;
`endif
    end else if (state != IDLE && as_s) begin
      // Abort from ASSERT/WAIT and normal release from DONE/BERR share one exit path.
      state        <= IDLE;
      MB_AS        <= STROBE_OFF;
      MB_UDS       <= STROBE_OFF;
      MB_LDS       <= STROBE_OFF;
      CPU_DTACK    <= STROBE_OFF;
      CYCLE_ACTIVE <= 1'b0;
      ds_pending   <= 1'b0;
`ifdef MB_BERR_TIMEOUT_EN
      CPU_BERR     <= STROBE_OFF;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!as_s && MB_SEL) begin
            state        <= ASSERT;
            MB_AS        <= 1'b0;
            CYCLE_ACTIVE <= 1'b1;
            dly_cnt      <= '0;
            if (CPU_RW || WR_DS_NOW) begin
              MB_UDS     <= uds_s;
              MB_LDS     <= lds_s;
              ds_pending <= 1'b0;
            end else begin
              ds_pending <= 1'b1;
            end
          end
        end
        ASSERT: begin
          if (!ds_pending || dly_cnt == 2'(DLY_LAST)) begin
            if (ds_pending) begin
              MB_UDS <= uds_s;
              MB_LDS <= lds_s;
            end
            ds_pending <= 1'b0;
            state      <= WAIT;
`ifdef MB_BERR_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end else begin
            dly_cnt <= dly_cnt + 2'd1;
          end
        end
        WAIT: begin
          if (!MB_DTACK || !MC6800_DTACK) begin
            state     <= DONE;
            CPU_DTACK <= 1'b0;
          end
`ifdef MB_BERR_TIMEOUT_EN
          else if (wait_cnt == MB_TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state    <= BERR;
            MB_AS    <= STROBE_OFF;
            MB_UDS   <= STROBE_OFF;
            MB_LDS   <= STROBE_OFF;
            CPU_BERR <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + MB_TIMEOUT_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef MB_BERR_TIMEOUT_EN
  assign CPU_BERR = STROBE_OFF;
`endif
endmodule

// File: tb/tb_mb_bus_cycle_sequencer.sv
// Scoreboard bench for mb_bus_cycle_sequencer; timeout cases run when MB_BERR_TIMEOUT_EN is defined.
module tb_mb_bus_cycle_sequencer;
  localparam logic [5:0] IDLE_V = 6'b111110;  // {MB_AS,MB_UDS,MB_LDS,CPU_DTACK,CPU_BERR,CYCLE_ACTIVE}

  typedef struct {
    int         cyc;
    logic [5:0] v;
    string      name;
  } ev_t;

  logic clk = 1'b0, rst = 1'b1;
  logic cpu_as = 1'b1, cpu_uds = 1'b1, cpu_lds = 1'b1, cpu_rw = 1'b1;
  logic mb_sel = 1'b0, mb_dtack = 1'b1, mc_dtack = 1'b1;
  logic mb_as, mb_uds, mb_lds, cpu_dtack, cpu_berr, cycle_active;
  logic [5:0] outs;
  logic [5:0] prev = 'x;
  ev_t exp_q[$];
  int cyc = 0, checks = 0, passed = 0;

  mb_bus_cycle_sequencer #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(16),
    .WR_DS_DELAY(1)
  ) dut (
    .MB_CLK(clk), .RESET(rst), .CPU_AS(cpu_as), .CPU_UDS(cpu_uds), .CPU_LDS(cpu_lds),
    .CPU_RW(cpu_rw), .MB_SEL(mb_sel), .MB_DTACK(mb_dtack), .MC6800_DTACK(mc_dtack),
    .MB_AS(mb_as), .MB_UDS(mb_uds), .MB_LDS(mb_lds), .CPU_DTACK(cpu_dtack),
    .CPU_BERR(cpu_berr), .CYCLE_ACTIVE(cycle_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign outs = {mb_as, mb_uds, mb_lds, cpu_dtack, cpu_berr, cycle_active};

  // Monitor: every output change must match the next expected event, at its cycle.
  always @(negedge clk) begin : mon
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      $display("FAIL %s: no output change at cycle %0d, required %b (outputs now %b)", e.name, e.cyc, e.v, outs);
    end
    if (outs !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected: outputs %b at cycle %0d, required unchanged %b", outs, cyc, prev);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.v === outs) passed++;
        else $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d", e.name, outs, cyc, e.v, e.cyc);
      end
      prev = outs;
    end
    if (mb_uds === 1'b0 || mb_lds === 1'b0) begin
      checks++;
      if (mb_as === 1'b0) passed++;
      else $display("FAIL ds_order: MB_AS=%b while a data strobe is low, required 0", mb_as);
    end
  end

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int c, input logic [5:0] v, input string n);
    ev_t e;
    e.cyc = c; e.v = v; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic rw, input logic u, input logic l);
    cpu_rw = rw; cpu_uds = u; cpu_lds = l; cpu_as = 1'b0;
  endtask

  task automatic stop_cpu();
    cpu_as = 1'b1; cpu_uds = 1'b1; cpu_lds = 1'b1;
  endtask

  initial begin : stim
    int b;
    expect_at(1, IDLE_V, "reset");
    go(3);
    rst = 1'b0;

    // Read, both strobes; MB_SEL dropped mid-cycle; then back-to-back read with both DTACKs together
    b = cyc + 4; go(b); mb_sel = 1'b1; start(1'b1, 1'b0, 1'b0);
    expect_at(b + 3, 6'b000111, "rd_assert");
    go(b + 4); mb_sel = 1'b0;
    go(b + 7); mb_dtack = 1'b0;
    expect_at(b + 8, 6'b000011, "rd_dtack");
    go(b + 9); mb_dtack = 1'b1;
    go(b + 10); stop_cpu();
    expect_at(b + 13, IDLE_V, "rd_end");
    go(b + 11); mb_sel = 1'b1; start(1'b1, 1'b0, 1'b1);
    expect_at(b + 14, 6'b001111, "b2b_assert");
    go(b + 18); mb_dtack = 1'b0; mc_dtack = 1'b0;
    expect_at(b + 19, 6'b001011, "both_dtack");
    go(b + 20); mb_dtack = 1'b1; mc_dtack = 1'b1; stop_cpu();
    expect_at(b + 23, IDLE_V, "b2b_end");

    // Write with one-cycle data strobe delay, completed by the 6800 stage
    b = cyc + 4; go(b); start(1'b0, 1'b0, 1'b0);
    expect_at(b + 3, 6'b011111, "wr_as");
    expect_at(b + 4, 6'b000111, "wr_ds");
    go(b + 13); mc_dtack = 1'b0;
    expect_at(b + 14, 6'b000011, "m6800_dtack");
    go(b + 15); mc_dtack = 1'b1; stop_cpu();
    expect_at(b + 18, IDLE_V, "wr_end");

    // Abort in WAIT: no DTACK ever
    b = cyc + 4; go(b); start(1'b1, 1'b1, 1'b0);
    expect_at(b + 3, 6'b010111, "ab_assert");
    go(b + 6); stop_cpu();
    expect_at(b + 9, IDLE_V, "abort");

`ifdef MB_BERR_TIMEOUT_EN
    b = cyc + 4; go(b); start(1'b1, 1'b0, 1'b0);
    expect_at(b + 3, 6'b000111, "to_assert");
    expect_at(b + 20, 6'b111101, "berr");
    go(b + 21); stop_cpu();
    expect_at(b + 24, IDLE_V, "berr_end");

    b = cyc + 4; go(b); start(1'b1, 1'b0, 1'b0);
    expect_at(b + 3, 6'b000111, "tc_assert");
    go(b + 19); mb_dtack = 1'b0;
    expect_at(b + 20, 6'b000011, "tc_dtack_wins");
    go(b + 21); mb_dtack = 1'b1; stop_cpu();
    expect_at(b + 24, IDLE_V, "tc_end");
`endif

    // MB_SEL=0: no motherboard strobes at all
    b = cyc + 4; go(b); mb_sel = 1'b0; start(1'b1, 1'b0, 1'b0);
    go(b + 8); stop_cpu();
    go(b + 12); mb_sel = 1'b1;

    // Reset while in DONE
    b = cyc + 4; go(b); start(1'b1, 1'b0, 1'b0);
    expect_at(b + 3, 6'b000111, "rs_assert");
    go(b + 4); mb_dtack = 1'b0;
    expect_at(b + 5, 6'b000011, "rs_dtack");
    go(b + 6); mb_dtack = 1'b1;
    go(b + 7); rst = 1'b1; stop_cpu();
    expect_at(b + 8, IDLE_V, "reset_in_done");
    go(b + 8); rst = 1'b0;

    go(cyc + 6);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
